// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: round-robin sharing of instruction-memory read channels among fetchers.
// Define IMEM_COALESCE_EN to serve every same-address requester from one memory read.
module imem_fetch_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 2,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_request,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_read_request,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic                                    busy
);
`ifdef IMEM_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif
    localparam int IW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT_MEM, RELAY} state_t;
    state_t                                  r_state    [NUM_CHANNELS];
    state_t                                  w_state_n  [NUM_CHANNELS];
    logic [IW-1:0]                           r_idx      [NUM_CHANNELS];
    logic [IW-1:0]                           w_idx_n    [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                r_served   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                w_served_n [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  r_addr, w_addr_n;
    logic [NUM_CHANNELS-1:0]                 r_mreq, w_mreq_n;
    logic [NUM_CONSUMERS-1:0]                r_ready, w_ready_n, r_taken, w_taken_n;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_data, w_data_n;
    logic [IW-1:0]                           r_rr, w_rr_n;
    // Channels are walked in index order so a grant or release by a lower channel is seen by higher ones.
    always_comb begin
        logic [IW-1:0] ptr, cand, sel;
        logic          found;
        w_state_n  = r_state;
        w_idx_n    = r_idx;
        w_served_n = r_served;
        w_addr_n   = r_addr;
        w_mreq_n   = r_mreq;
        w_ready_n  = r_ready;
        w_data_n   = r_data;
        w_taken_n  = r_taken;
        w_rr_n     = r_rr;
        ptr        = r_rr;
        cand       = '0;
        sel        = '0;
        found      = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            found = 1'b0;
            sel   = '0;
            if (r_state[ch] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    cand = IW'((int'(ptr) + k) % NUM_CONSUMERS);
                    if (!found && consumer_read_request[cand] && !w_taken_n[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                if (found) begin
                    w_state_n[ch]       = WAIT_MEM;
                    w_idx_n[ch]         = sel;
                    w_addr_n[ch]        = consumer_read_address[sel];
                    w_mreq_n[ch]        = 1'b1;
                    w_taken_n[sel]      = 1'b1;
                    w_served_n[ch]      = '0;
                    w_served_n[ch][sel] = 1'b1;
                    ptr                 = IW'((int'(sel) + 1) % NUM_CONSUMERS);
                    w_rr_n              = ptr;
                end
            end else if (r_state[ch] == WAIT_MEM) begin
                if (mem_read_ready[ch]) begin
                    w_state_n[ch]         = RELAY;
                    w_mreq_n[ch]          = 1'b0;
                    w_ready_n[r_idx[ch]]  = 1'b1;
                    w_data_n[r_idx[ch]]   = mem_read_data[ch];
                    for (int c = 0; c < NUM_CONSUMERS; c++) begin
                        if (COALESCE && consumer_read_request[c] && !w_taken_n[c] &&
                            consumer_read_address[c] == r_addr[ch]) begin
                            w_ready_n[c]      = 1'b1;
                            w_data_n[c]       = mem_read_data[ch];
                            w_taken_n[c]      = 1'b1;
                            w_served_n[ch][c] = 1'b1;
                        end
                    end
                end
            end else begin
                for (int c = 0; c < NUM_CONSUMERS; c++) begin
                    if (r_served[ch][c] && !consumer_read_request[c])
                        w_ready_n[c] = 1'b0;
                end
                if ((r_served[ch] & consumer_read_request) == '0) begin
                    w_state_n[ch]  = IDLE;
                    w_taken_n      = w_taken_n & ~r_served[ch];
                    w_served_n[ch] = '0;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= '{default: IDLE};
            r_idx    <= '{default: '0};
            r_served <= '{default: '0};
            r_addr   <= '0;
            r_mreq   <= '0;
            r_ready  <= '0;
            r_data   <= '0;
            r_taken  <= '0;
            r_rr     <= '0;
        end else begin
            r_state  <= w_state_n;
            r_idx    <= w_idx_n;
            r_served <= w_served_n;
            r_addr   <= w_addr_n;
            r_mreq   <= w_mreq_n;
            r_ready  <= w_ready_n;
            r_data   <= w_data_n;
            r_taken  <= w_taken_n;
            r_rr     <= w_rr_n;
        end
    end
    always_comb begin
        busy = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
            busy = busy | (r_state[ch] != IDLE);
    end
    assign consumer_read_ready = r_ready;
    assign consumer_read_data  = r_data;
    assign mem_read_request    = r_mreq;
    assign mem_read_address    = r_addr;
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: vector table and corner sequences on a 2-fetcher/1-channel instance,
// plus randomized traffic on a 3-fetcher/2-channel instance checked against a memory/fetcher model.
module tb_imem_fetch_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        req1;
    logic [1:0][7:0]   addr1;
    logic [1:0]        rdy1;
    logic [1:0][15:0]  data1;
    logic [0:0]        mreq1;
    logic [0:0][7:0]   maddr1;
    logic [0:0]        mrdy1;
    logic [0:0][15:0]  mdata1;
    logic              busy1;

    logic [2:0]        req2;
    logic [2:0][7:0]   addr2;
    logic [2:0]        rdy2;
    logic [2:0][15:0]  data2;
    logic [1:0]        mreq2;
    logic [1:0][7:0]   maddr2;
    logic [1:0]        mrdy2;
    logic [1:0][15:0]  mdata2;
    logic              busy2;

    imem_fetch_arbiter dut1 (
        .clk(clk), .reset(rst_n),
        .consumer_read_request(req1), .consumer_read_address(addr1),
        .consumer_read_ready(rdy1), .consumer_read_data(data1),
        .mem_read_request(mreq1), .mem_read_address(maddr1),
        .mem_read_ready(mrdy1), .mem_read_data(mdata1), .busy(busy1)
    );

    imem_fetch_arbiter #(.NUM_CONSUMERS(3), .NUM_CHANNELS(2)) dut2 (
        .clk(clk), .reset(rst_n),
        .consumer_read_request(req2), .consumer_read_address(addr2),
        .consumer_read_ready(rdy2), .consumer_read_data(data2),
        .mem_read_request(mreq2), .mem_read_address(maddr2),
        .mem_read_ready(mrdy2), .mem_read_data(mdata2), .busy(busy2)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents of the random-traffic model: high byte is the address, low byte its inverse.
    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a, ~a};
    endfunction

    typedef struct {
        logic [1:0]  mask;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [15:0] d;
        int          lat;
        int          win;
    } vec_t;
    vec_t tbl[8];

    int  n, w, reads, completions, rises;
    int  hold[3], waitc[3], mwait[2];
    bit  armed[2], real_rdy[2], prev_rdy[3], stop, hit;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        // Winners follow the round-robin pointer: it starts at 0 and moves past each grant.
        tbl[0] = '{2'b01, 8'h10, 8'h11, 16'hABCD, 3, 0};
        tbl[1] = '{2'b11, 8'h20, 8'h21, 16'h1111, 1, 1};
        tbl[2] = '{2'b11, 8'h22, 8'h23, 16'h2222, 2, 0};
        tbl[3] = '{2'b10, 8'h24, 8'h25, 16'h3333, 1, 1};
        tbl[4] = '{2'b10, 8'h26, 8'h27, 16'h4444, 2, 1};
        tbl[5] = '{2'b11, 8'h28, 8'h29, 16'h5555, 1, 0};
        tbl[6] = '{2'b01, 8'h2A, 8'h2B, 16'h6666, 4, 0};
        tbl[7] = '{2'b11, 8'h2C, 8'h2D, 16'h7777, 1, 1};
        req1 = '0; addr1 = '0; mrdy1 = '0; mdata1 = '0;
        req2 = '0; addr2 = '0; mrdy2 = '0; mdata2 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready1", 32'(rdy1), 0);
        check("rst_data1", 32'(data1), 0);
        check("rst_mreq1", 32'(mreq1), 0);
        check("rst_maddr1", 32'(maddr1), 0);
        check("rst_busy1", 32'(busy1), 0);
        check("rst_mreq2", 32'(mreq2), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            addr1[0] = tbl[i].a0;
            addr1[1] = tbl[i].a1;
            req1     = tbl[i].mask;
            @(negedge clk);
            check($sformatf("t%0d_mreq", i), 32'(mreq1), 1);
            check($sformatf("t%0d_maddr", i), 32'(maddr1[0]), 32'(tbl[i].win ? tbl[i].a1 : tbl[i].a0));
            repeat (tbl[i].lat - 1) @(negedge clk);
            mrdy1[0] = 1'b1;
            mdata1[0] = tbl[i].d;
            @(negedge clk);
            mrdy1 = '0;
            check($sformatf("t%0d_ready", i), 32'(rdy1), tbl[i].win ? 2 : 1);
            check($sformatf("t%0d_data", i), 32'(data1[tbl[i].win]), 32'(tbl[i].d));
            check($sformatf("t%0d_mreq_low", i), 32'(mreq1), 0);
            repeat (2) @(negedge clk);
            check($sformatf("t%0d_ready_hold", i), 32'(rdy1), tbl[i].win ? 2 : 1);
            req1 = '0;
            @(negedge clk);
            check($sformatf("t%0d_ready_drop", i), 32'(rdy1), 0);
            check($sformatf("t%0d_busy", i), 32'(busy1), 0);
        end

        // Continuous requesters alternate; the pointer is back at 0 after the table.
        addr1[0] = 8'h50;
        addr1[1] = 8'h51;
        req1 = 2'b11;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!mreq1[0] && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("rr%0d_mreq", g), 32'(mreq1), 1);
            check($sformatf("rr%0d_grant", g), 32'(maddr1[0]), (g % 2) ? 32'h51 : 32'h50);
            w = (maddr1[0] == 8'h51) ? 1 : 0;
            mrdy1[0] = 1'b1;
            mdata1[0] = 16'h9000 + 16'(g);
            @(negedge clk);
            mrdy1 = '0;
            check($sformatf("rr%0d_ready", g), 32'(rdy1), w ? 2 : 1);
            req1[w] = 1'b0;
            @(negedge clk);
            req1[w] = 1'b1;
        end
        req1 = '0;
        repeat (2) @(negedge clk);
        check("rr_idle", 32'(busy1), 0);

        // Asynchronous reset in WAIT_MEM, then a clean transaction.
        addr1[0] = 8'h40;
        req1 = 2'b01;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mreq", 32'(mreq1), 0);
        check("arst_maddr", 32'(maddr1), 0);
        check("arst_busy", 32'(busy1), 0);
        check("arst_ready", 32'(rdy1), 0);
        req1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        addr1[1] = 8'h05;
        req1 = 2'b10;
        @(negedge clk);
        check("post_rst_mreq", 32'(mreq1), 1);
        check("post_rst_maddr", 32'(maddr1[0]), 32'h05);
        mrdy1[0] = 1'b1;
        mdata1[0] = 16'h1234;
        @(negedge clk);
        mrdy1 = '0;
        check("post_rst_ready", 32'(rdy1), 2);
        check("post_rst_data", 32'(data1[1]), 32'h1234);
        @(negedge clk);
        check("post_rst_one_read", 32'(mreq1), 0);
        req1 = '0;
        @(negedge clk);

        // Request withdrawn during WAIT_MEM: read completes and ready pulses once.
        addr1[0] = 8'h60;
        req1 = 2'b01;
        @(negedge clk);
        req1 = '0;
        @(negedge clk);
        mrdy1[0] = 1'b1;
        mdata1[0] = 16'hBEEF;
        @(negedge clk);
        mrdy1 = '0;
        check("drop_pulse", 32'(rdy1), 1);
        check("drop_data", 32'(data1[0]), 32'hBEEF);
        @(negedge clk);
        check("drop_ready_clr", 32'(rdy1), 0);
        check("drop_idle", 32'(busy1), 0);

        // Stray memory ready with no transaction in flight.
        mrdy1[0] = 1'b1;
        mdata1[0] = 16'hDEAD;
        @(negedge clk);
        mrdy1 = '0;
        @(negedge clk);
        check("stray_ready", 32'(rdy1), 0);
        check("stray_busy", 32'(busy1), 0);

        // Two fetchers asking for the same word.
        addr1[0] = 8'h30;
        addr1[1] = 8'h30;
        req1 = 2'b11;
        reads = 0;
        @(negedge clk);
        check("coal_mreq", 32'(mreq1), 1);
        check("coal_maddr", 32'(maddr1[0]), 32'h30);
        mrdy1[0] = 1'b1;
        mdata1[0] = 16'h5555;
        reads++;
        @(negedge clk);
        mrdy1 = '0;
`ifdef IMEM_COALESCE_EN
        check("coal_both_ready", 32'(rdy1), 3);
        check("coal_data", 32'(data1), 32'h55555555);
        req1 = 2'b10;
        @(negedge clk);
        check("coal_partial_ready", 32'(rdy1), 2);
        check("coal_busy_held", 32'(busy1), 1);
        check("coal_no_second_read", 32'(mreq1), 0);
        req1 = '0;
        @(negedge clk);
        check("coal_reads", 32'(reads), 1);
`else
        check("coal_one_ready", 32'($countones(rdy1)), 1);
        w = rdy1[1] ? 1 : 0;
        check("coal_data", 32'(data1[w]), 32'h5555);
        req1[w] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mreq1[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("coal_second_mreq", 32'(mreq1), 1);
        check("coal_second_maddr", 32'(maddr1[0]), 32'h30);
        mrdy1[0] = 1'b1;
        reads++;
        @(negedge clk);
        mrdy1 = '0;
        check("coal_second_ready", 32'(rdy1), w ? 1 : 2);
        check("coal_second_data", 32'(data1[1-w]), 32'h5555);
        check("coal_reads", 32'(reads), 2);
        req1 = '0;
`endif
        @(negedge clk);
        check("coal_idle", 32'(busy1), 0);

        // Two channels grant two fetchers in the same cycle.
        addr2[0] = 8'h20;
        addr2[1] = 8'h21;
        req2 = 3'b011;
        @(negedge clk);
        check("dual_mreq", 32'(mreq2), 3);
        check("dual_maddr0", 32'(maddr2[0]), 32'h20);
        check("dual_maddr1", 32'(maddr2[1]), 32'h21);
        mrdy2 = 2'b11;
        mdata2[0] = 16'hC0C0;
        mdata2[1] = 16'hC1C1;
        @(negedge clk);
        mrdy2 = '0;
        check("dual_ready", 32'(rdy2), 3);
        check("dual_data0", 32'(data2[0]), 32'hC0C0);
        check("dual_data1", 32'(data2[1]), 32'hC1C1);
        req2 = '0;
        @(negedge clk);
        check("dual_idle", 32'(busy2), 0);

        // Random traffic on the dual-channel instance.
        completions = 0;
        rises = 0;
        stop = 0;
        for (int c = 0; c < 3; c++) begin
            hold[c] = 0;
            waitc[c] = 0;
            prev_rdy[c] = 0;
        end
        for (int ch = 0; ch < 2; ch++) begin
            armed[ch] = 0;
            real_rdy[ch] = 0;
            mwait[ch] = 0;
        end
        for (int cyc = 0; cyc < 3200; cyc++) begin
            @(negedge clk);
            stop = (cyc >= 3000);
            for (int ch = 0; ch < 2; ch++) begin
                if (mrdy2[ch]) begin
                    mrdy2[ch] = 1'b0;
                    if (real_rdy[ch]) check("rnd_mreq_release", 32'(mreq2[ch]), 0);
                    real_rdy[ch] = 0;
                end else if (mreq2[ch]) begin
                    if (!armed[ch]) begin
                        armed[ch] = 1;
                        mwait[ch] = $urandom_range(0, 3);
                    end
                    if (mwait[ch] == 0) begin
                        hit = 0;
                        for (int c = 0; c < 3; c++)
                            if (req2[c] && !rdy2[c] && addr2[c] == maddr2[ch]) hit = 1;
                        check("rnd_maddr_owner", 32'(hit), 1);
                        mrdy2[ch] = 1'b1;
                        mdata2[ch] = mem_word(maddr2[ch]);
                        armed[ch] = 0;
                        real_rdy[ch] = 1;
                        completions++;
                    end else begin
                        mwait[ch]--;
                    end
                end else if (!stop && $urandom_range(0, 15) == 0) begin
                    mrdy2[ch] = 1'b1;
                    mdata2[ch] = 16'hDEAD;
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (req2[c]) begin
                    if (rdy2[c]) begin
                        check("rnd_data", 32'(data2[c]), 32'(mem_word(addr2[c])));
                        if (!prev_rdy[c]) begin
                            rises++;
                            check("rnd_wait_bound", 32'(waitc[c] <= 80), 1);
                        end
                        waitc[c] = 0;
                        if (hold[c] == 0) req2[c] = 1'b0;
                        else hold[c]--;
                    end else begin
                        waitc[c]++;
                    end
                end else begin
                    check("rnd_idle_ready", 32'(rdy2[c]), 0);
                    if (!stop && $urandom_range(0, 2) == 0) begin
                        req2[c] = 1'b1;
                        addr2[c] = 8'($urandom_range(0, 3));
                        hold[c] = $urandom_range(0, 3);
                        waitc[c] = 0;
                    end
                end
                prev_rdy[c] = rdy2[c];
            end
        end
        repeat (2) @(negedge clk);
        check("rnd_drained_req", 32'(req2), 0);
        check("rnd_drained_busy", 32'(busy2), 0);
`ifdef IMEM_COALESCE_EN
        check("rnd_rises_cover_reads", 32'(rises >= completions), 1);
`else
        check("rnd_one_ready_per_read", 32'(rises), 32'(completions));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares the instruction-memory read channels among the per-core fetchers.
- Each fetcher issues a level-held read request with an address. The block grants free channels round-robin, forwards the read to memory, and returns the data to the winning fetcher with a ready handshake.
- Sits between the cores' fetcher ports and the top-level instruction_mem_* ports. Read-only; there is no write path.

Parameters:
- ADDR_BITS, 8, instruction memory address width.
- DATA_BITS, 16, instruction word width.
- NUM_CONSUMERS, 2, number of fetchers (one per core), at least 1.
- NUM_CHANNELS, 1, number of concurrent memory channels, 1 to NUM_CONSUMERS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- consumer_read_request  in  [NUM_CONSUMERS-1:0]  per-fetcher request, held until data received.
- consumer_read_address  in  [ADDR_BITS-1:0] x NUM_CONSUMERS  per-fetcher address, stable while request is high.
- consumer_read_ready  out  [NUM_CONSUMERS-1:0]  data valid for that fetcher.
- consumer_read_data  out  [DATA_BITS-1:0] x NUM_CONSUMERS  returned instruction word.
- mem_read_request  out  [NUM_CHANNELS-1:0]  per-channel memory read request.
- mem_read_address  out  [ADDR_BITS-1:0] x NUM_CHANNELS  per-channel address.
- mem_read_ready  in  [NUM_CHANNELS-1:0]  memory data valid.
- mem_read_data  in  [DATA_BITS-1:0] x NUM_CHANNELS  memory read data.
- busy  out  1  high when any channel is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0, including data buses.
  - Every channel is IDLE; per-consumer taken mask = 0; rr_ptr = 0.
- Per-channel FSM, with states IDLE, WAIT_MEM and RELAY:
  - IDLE: selects a consumer with request=1 and taken=0, searching from rr_ptr upward with wrap-around. On grant it latches the consumer index and address, sets taken[c], drives mem_read_request=1 and mem_read_address, and moves to WAIT_MEM. Memory request appears 1 cycle after the consumer request is first sampled.
  - WAIT_MEM: holds request and address. On mem_read_ready=1 it sets mem_read_request=0, consumer_read_ready[c]=1, consumer_read_data[c]=mem_read_data, and moves to RELAY.
  - RELAY: holds ready and data. When consumer_read_request[c]=0 it clears ready, clears taken[c], and returns to IDLE. A fetcher may issue its next request no earlier than the cycle after ready drops.
- Multi-channel arbitration within one cycle:
  - Channels are evaluated in ascending index order.
  - A consumer granted by a lower channel is excluded from higher channels in that same cycle.
  - Each channel continues its search from just past the previous grant.
  - After any grants, rr_ptr = (last granted index + 1) mod NUM_CONSUMERS; it is unchanged if there were no grants.
- Boundary conditions:
  - mem_read_ready while IDLE or RELAY is ignored.
  - A consumer dropping its request during WAIT_MEM violates protocol. The channel still completes the read, pulses ready for 1 cycle, then returns to IDLE.
  - If all channels are busy, extra requests wait with no loss. A held request is granted within NUM_CONSUMERS channel-release events.
  - A consumer is never served by two channels at once.
  - Returned data is not modified; there is no width conversion.
- busy = OR over channels of (state != IDLE).

Optional Feature:
- Macro: IMEM_COALESCE_EN.
- Enabled:
  - In WAIT_MEM, on mem_read_ready, every other consumer with request=1, taken=0 and an address equal to the latched address also receives ready and the same data, and is marked taken. This is recorded in a per-channel served mask.
  - RELAY returns to IDLE only when every served consumer has dropped its request; ready for each consumer clears individually as its request drops.
- Disabled: exactly one consumer is served per transaction.

Test Plan:
- Reset mid-transaction:
  - Stimulus: drive reset=0 asynchronously while in WAIT_MEM; release it; then consumer 1 requests 0x05 and memory returns 0x1234.
  - Response: all outputs go 0 immediately. After release, one mem_read_request is issued with address 0x05.
- Single request:
  - Stimulus: consumer 0 requests 0x10; memory asserts ready 3 cycles later with 0xABCD.
  - Response: mem_read_request rises 1 cycle after the request, with address 0x10. consumer_read_ready[0]=1 with 0xABCD the cycle after mem ready, and stays high until the request drops.
- Round-robin fairness:
  - Stimulus: 1 channel; consumers 0 and 1 both hold requests continuously, re-requesting one cycle after each ready drops.
  - Response: grant order is 0, 1, 0, 1.
- Two channels:
  - Stimulus: NUM_CHANNELS=2; consumers 0 and 1 request 0x20 and 0x21 in the same cycle.
  - Response: channel 0 gets 0x20 and channel 1 gets 0x21 in the same cycle; no duplicate grants.
- Coalescing (macro set):
  - Stimulus: consumers 0 and 1 both request 0x30 in the same cycle; memory returns 0x5555.
  - Response: exactly one memory read; both readies assert with 0x5555 in the same cycle. busy stays 1 until both requests drop.
- Coalescing (macro unset):
  - Stimulus: same as above.
  - Response: two sequential memory reads of 0x30.
